// File: rtl/axil_read_master_pkg.sv
// axil_read_master_pkg: shared encodings for the AXI-Lite read path
package axil_read_master_pkg;
    typedef enum logic [2:0] {IDLE, AR, R, RESP, DRAIN} state_e;
    localparam logic [1:0] SIZE_B = 2'd0, SIZE_H = 2'd1, SIZE_W = 2'd2;
    localparam logic [1:0] OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11;
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == SIZE_B) ? 1'b0 : (size == SIZE_H) ? off[0] : (size == SIZE_W) ? |off : 1'b1;
    endfunction
endpackage

// File: rtl/axil_read_master_if.sv
// axil_read_master_if: core load request/response plus AXI-Lite AR/R channels
interface axil_read_master_if #(parameter int DATA_WIDTH = 32, parameter int ADDR_WIDTH = 32);
    logic                  req_valid, req_ready, req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [1:0]            req_size;
    logic                  resp_valid, resp_ready, resp_err;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [ADDR_WIDTH-1:0] m_araddr;
    logic                  m_arvalid, m_arready, m_rvalid, m_rready;
    logic [DATA_WIDTH-1:0] m_rdata;
    logic [1:0]            m_rresp;
    modport master (
        input  req_valid, req_addr, req_size, req_signed, resp_ready, m_arready, m_rdata, m_rresp, m_rvalid,
        output req_ready, resp_valid, resp_data, resp_err, m_araddr, m_arvalid, m_rready
    );
    modport slave (
        output req_valid, req_addr, req_size, req_signed, resp_ready, m_arready, m_rdata, m_rresp, m_rvalid,
        input  req_ready, resp_valid, resp_data, resp_err, m_araddr, m_arvalid, m_rready
    );
endinterface

// File: rtl/axil_load_align.sv
// axil_load_align: byte-lane extraction and sign/zero extension of a 32-bit load beat
module axil_load_align import axil_read_master_pkg::*; (
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = rdata_i[{off_i, 3'b000} +: 8];
    assign h = rdata_i[{off_i[1], 4'b0000} +: 16];
    assign data_o = (size_i == SIZE_B) ? {{24{signed_i & b[7]}}, b}
                  : (size_i == SIZE_H) ? {{16{signed_i & h[15]}}, h} : rdata_i;
endmodule

// File: rtl/axil_read_master.sv
// axil_read_master: single-outstanding AXI-Lite load initiator with alignment, error and timeout handling
module axil_read_master import axil_read_master_pkg::*; #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic clk,
    input logic rst,
    axil_read_master_if.master bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  sgn_q, sgn_d, err_q, err_d, pend_q, pend_d, live_q;
    logic [DATA_WIDTH-1:0] data_q, data_d, aligned;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  bus_err;
    axil_load_align u_align (
        .rdata_i (bus.m_rdata),
        .off_i   (addr_q[1:0]),
        .size_i  (size_q),
        .signed_i(sgn_q),
        .data_o  (aligned)
    );
    assign bus_err = (bus.m_rresp == SLVERR) || (bus.m_rresp == DECERR);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            data_q  <= data_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
        end
    end
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        data_d  = data_q;
        err_d   = err_q;
        pend_d  = pend_q;
        cnt_d   = (state_q != R) ? '0 : (cnt_q == CW'(TIMEOUT_CYCLES)) ? cnt_q : cnt_q + 1'b1;
        case (state_q)
            IDLE: if (bus.req_valid && live_q) begin
                addr_d  = bus.req_addr;
                size_d  = bus.req_size;
                sgn_d   = bus.req_signed;
                data_d  = '0;
                err_d   = misaligned(bus.req_size, bus.req_addr[1:0]);
                state_d = err_d ? RESP : AR;
            end
            AR: state_d = bus.m_arready ? R : AR;
            // a beat in the timeout cycle still wins over the timeout
            R: if (bus.m_rvalid) begin
                data_d  = bus_err ? '0 : aligned;
                err_d   = bus_err;
                state_d = RESP;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                data_d  = '0;
                err_d   = 1'b1;
                pend_d  = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                pend_d  = pend_q && !bus.m_rvalid;
                state_d = !bus.resp_ready ? RESP : pend_d ? DRAIN : IDLE;
            end
            DRAIN: state_d = bus.m_rvalid ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    assign bus.req_ready  = live_q && (state_q == IDLE);
    assign bus.m_arvalid  = (state_q == AR);
    assign bus.m_araddr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign bus.m_rready   = (state_q == R) || (state_q == DRAIN) || ((state_q == RESP) && pend_q);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_data  = data_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_axil_read_master.sv
// tb_axil_read_master: directed loads against a per-cycle behavioural reference
module tb_axil_read_master;
    localparam int TMO = 4;
    logic clk, rst;
    int checks = 0, failures = 0;
    logic [31:0] exp_data, exp_araddr;
    logic        exp_err;
    bit          exp_mis = 0, busy = 0, pv_ar = 0, pv_rv = 0;

    axil_read_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
    axil_read_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic bit mis_f(input logic [31:0] a, input logic [1:0] sz);
        return sz == 3 || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
    endfunction

    // reference: {err, data} of a load from its request and returned beat
    function automatic logic [32:0] model(input logic [31:0] a, input logic [1:0] sz, input bit sg,
                                          input logic [31:0] rd, input logic [1:0] rr, input bit tmo);
        logic [31:0] v;
        int off = int'(a % 4);
        if (mis_f(a, sz) || tmo || rr >= 2) return {1'b1, 32'h0};
        v = rd >> (8 * off);
        if (sz == 0) begin
            v = v % 256;
            if (sg && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 1) begin
            v = v % 65536;
            if (sg && v >= 32768) v = v + 32'hFFFF0000;
        end
        return {1'b0, v};
    endfunction

    task automatic chk_zero(input string nm);
        chk({nm, "_req_ready"}, bus.req_ready, 0);
        chk({nm, "_resp_valid"}, bus.resp_valid, 0);
        chk({nm, "_resp_data"}, bus.resp_data, 0);
        chk({nm, "_resp_err"}, bus.resp_err, 0);
        chk({nm, "_araddr"}, bus.m_araddr, 0);
        chk({nm, "_arvalid"}, bus.m_arvalid, 0);
        chk({nm, "_rready"}, bus.m_rready, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (rst) begin
            pv_ar = 0;
            pv_rv = 0;
        end else begin
            if (bus.resp_valid) begin
                chk("resp_data", bus.resp_data, exp_data);
                chk("resp_err", bus.resp_err, exp_err);
            end
            if (bus.m_arvalid) chk("araddr", bus.m_araddr, exp_araddr);
            if (exp_mis) chk("no_arvalid", bus.m_arvalid, 0);
            if (busy) chk("req_ready_busy", bus.req_ready, 0);
            if (pv_ar && !bus.m_arready) chk("arvalid_held", bus.m_arvalid, 1);
            if (pv_rv && !bus.resp_ready) chk("resp_held", bus.resp_valid, 1);
            pv_ar = bus.m_arvalid;
            pv_rv = bus.resp_valid;
        end
    end

    // rw < 0 withholds the beat until the timeout, then returns it late in DRAIN
    task automatic run_load(input string nm, input logic [31:0] addr, input logic [1:0] size, input bit sg,
                            input logic [31:0] rd, input logic [1:0] rr, input int arw, input int rw,
                            input int respw, input bit hold, input logic lit_err, input logic [31:0] lit_data);
        int cyc = 1, ars = 0, rs = 0, rps = 0, ds = 0, lat_exp;
        bit got = 0, done = 0, drain = 0;
        {exp_err, exp_data} = model(addr, size, sg, rd, rr, rw < 0);
        exp_mis    = mis_f(addr, size);
        exp_araddr = addr & 32'hFFFFFFFC;
        lat_exp    = exp_mis ? 1 : (rw < 0) ? 2 + arw + TMO : 3 + arw + rw;
        @(negedge clk);
        chk({nm, "_req_ready_idle"}, bus.req_ready, 1);
        bus.req_valid = 1; bus.req_addr = addr; bus.req_size = size; bus.req_signed = sg;
        bus.m_rdata = rd; bus.m_rresp = rr;
        @(negedge clk);
        busy = 1;
        bus.req_valid = hold;
        if (hold) begin bus.req_addr = 32'h90000000; bus.req_size = 2; end
        while (!done && cyc < 200) begin
            if (cyc == 1) chk({nm, "_arvalid_c1"}, bus.m_arvalid, !exp_mis);
            bus.m_arready = bus.m_arvalid && ars >= arw;
            if (bus.m_arvalid) ars++;
            bus.m_rvalid = drain ? (bus.m_rready && ds >= 2) : (rw >= 0 && bus.m_rready && rs >= rw);
            if (bus.m_rready && !bus.resp_valid && !drain) rs++;
            if (bus.resp_valid && !got) begin
                got = 1;
                chk({nm, "_latency"}, cyc, lat_exp);
                chk({nm, "_lit_err"}, bus.resp_err, lit_err);
                chk({nm, "_lit_data"}, bus.resp_data, lit_data);
            end
            bus.resp_ready = bus.resp_valid && rps >= respw;
            if (bus.resp_valid) rps++;
            if (drain) begin
                chk({nm, "_drain_req_ready"}, bus.req_ready, 0);
                if (bus.m_rvalid) begin busy = 0; done = 1; end
                ds++;
            end else if (bus.resp_ready) begin
                if (rw < 0) drain = 1;
                else begin busy = 0; done = 1; bus.req_valid = 0; end
            end
            @(negedge clk);
            cyc++;
        end
        if (!done) chk({nm, "_timeout"}, 0, 1);
        busy = 0;
        bus.req_valid = 0; bus.m_arready = 0; bus.m_rvalid = 0; bus.resp_ready = 0;
        chk({nm, "_req_ready_after"}, bus.req_ready, 1);
    endtask

    initial begin
        rst = 1;
        bus.req_valid = 0; bus.req_addr = 0; bus.req_size = 0; bus.req_signed = 0; bus.resp_ready = 0;
        bus.m_arready = 0; bus.m_rdata = 0; bus.m_rresp = 0; bus.m_rvalid = 0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 0;
        run_load("word",      32'ha0000048, 2, 0, 32'h12345678, 2'b00, 0, 0, 0, 0, 0, 32'h12345678);
        run_load("byte_s",    32'h80000003, 0, 1, 32'h80FF7F01, 2'b00, 0, 0, 0, 0, 0, 32'hFFFFFF80);
        run_load("byte_u",    32'h80000003, 0, 0, 32'h80FF7F01, 2'b00, 0, 0, 0, 0, 0, 32'h00000080);
        run_load("half_s",    32'h80000002, 1, 1, 32'hBEEF1234, 2'b00, 0, 0, 0, 0, 0, 32'hFFFFBEEF);
        run_load("mis_word",  32'h80000001, 2, 0, 32'h11111111, 2'b00, 0, 0, 0, 0, 1, 32'h0);
        run_load("size3",     32'h80000000, 3, 0, 32'h11111111, 2'b00, 0, 0, 0, 0, 1, 32'h0);
        run_load("mis_half",  32'h80000001, 1, 1, 32'h11111111, 2'b00, 0, 0, 0, 0, 1, 32'h0);
        run_load("decerr",    32'h80000004, 2, 0, 32'hDEADBEEF, 2'b11, 0, 0, 0, 0, 1, 32'h0);
        run_load("slverr",    32'h80000005, 0, 1, 32'hDEADBEEF, 2'b10, 1, 1, 1, 0, 1, 32'h0);
        run_load("exokay",    32'h80000001, 0, 0, 32'h0000AB00, 2'b01, 0, 2, 0, 0, 0, 32'h000000AB);
        run_load("timeout",   32'h80000010, 2, 0, 32'hCAFEF00D, 2'b00, 0, -1, 1, 0, 1, 32'h0);
        run_load("after_drn", 32'h80000014, 2, 0, 32'h0BADF00D, 2'b00, 0, 0, 0, 0, 0, 32'h0BADF00D);
        run_load("backpress", 32'h80000008, 1, 1, 32'h00017FFF, 2'b00, 5, 1, 3, 1, 0, 32'h00007FFF);
        // reset while waiting in R
        {exp_err, exp_data} = model(32'h80000020, 2, 0, 32'h0, 2'b00, 0);
        exp_mis = 0; exp_araddr = 32'h80000020;
        @(negedge clk);
        bus.req_valid = 1; bus.req_addr = 32'h80000020; bus.req_size = 2; bus.req_signed = 0;
        @(negedge clk);
        bus.req_valid = 0; busy = 1; bus.m_arready = 1;
        @(negedge clk);
        bus.m_arready = 0;
        chk("rst_mid_rready", bus.m_rready, 1);
        rst = 1; busy = 0;
        @(negedge clk);
        chk_zero("rst_mid");
        rst = 0;
        run_load("recover",   32'h80000022, 1, 0, 32'h8001FFFF, 2'b00, 0, 0, 0, 0, 0, 32'h00008001);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
